// File: rtl/v4_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : v4_pulse_generator
// Purpose  : Synthetic ADC pulse source (baseline + linear rise + exponential
//            decay tail), single-shot or periodic with pile-up on the live tail.
//            Optional dither noise: define V4_PULSE_GEN_NOISE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module v4_pulse_generator #(
    parameter int DATA_W      = 12,
    parameter int FRAC_W      = 12,
    parameter int RISE_SHIFT  = 2,
    parameter int DECAY_SHIFT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] amplitude,
    input  logic [DATA_W-1:0] baseline,
    input  logic [15:0]       period,
    output logic              busy,
    output logic              pulse_strobe,
    output logic [DATA_W-1:0] output_data
);

    localparam int ACC_W    = DATA_W + FRAC_W;
    localparam int RISE_LEN = 2 ** RISE_SHIFT;
    localparam int RCNT_W   = RISE_SHIFT + 1;
    localparam int STEP_SH  = FRAC_W - RISE_SHIFT;

    localparam logic [RCNT_W-1:0] c_rise_last  = RCNT_W'(RISE_LEN - 1);
    localparam logic [15:0]       c_min_period = 16'(RISE_LEN + 1);
    localparam logic [ACC_W-1:0]  c_acc_max    = '1;
    localparam logic [DATA_W-1:0] c_data_max   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RISE  = 2'd1,
        S_DECAY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_n;
    logic [RCNT_W-1:0]   r_rise_cnt;
    logic [RCNT_W-1:0]   w_rise_cnt_n;
    logic [15:0]         r_period_cnt;
    logic [15:0]         w_period_cnt_n;
    logic [DATA_W-1:0]   r_amp;
    logic [DATA_W-1:0]   r_base;
    logic [15:0]         r_period;
    logic                r_peak;
    logic                w_peak_n;
    logic                w_load;
    logic                r_busy;
    logic                r_strobe;
    logic [DATA_W-1:0]   r_out;
    logic [DATA_W-1:0]   w_out_n;

    logic [ACC_W-1:0]    w_step;
    logic [ACC_W:0]      w_acc_sum;
    logic [ACC_W-1:0]    w_acc_rise;
    logic [ACC_W-1:0]    w_acc_decay;
    logic [DATA_W-1:0]   w_acc_int;
    logic [15:0]         w_period_eff;
    logic                w_period_hit;
    logic [DATA_W-1:0]   w_base_sel;
    logic [DATA_W:0]     w_sum;

    assign w_step       = ACC_W'(r_amp) << STEP_SH;
    assign w_acc_sum    = {1'b0, r_acc} + {1'b0, w_step};
    // Pile-up can push the accumulator past full scale; clamp instead of wrapping.
    assign w_acc_rise   = w_acc_sum[ACC_W] ? c_acc_max : w_acc_sum[ACC_W-1:0];
    assign w_acc_decay  = r_acc - (r_acc >> DECAY_SHIFT);
    assign w_acc_int    = r_acc[ACC_W-1:FRAC_W];
    assign w_period_eff = (r_period < c_min_period) ? c_min_period : r_period;
    assign w_period_hit = (r_period_cnt == (w_period_eff - 16'd1));

    always_comb begin
        w_state_n      = r_state;
        w_acc_n        = r_acc;
        w_rise_cnt_n   = r_rise_cnt;
        w_period_cnt_n = r_period_cnt;
        w_load         = 1'b0;
        w_peak_n       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_acc_n        = '0;
                w_rise_cnt_n   = '0;
                w_period_cnt_n = '0;
                if (start && !stop) begin
                    w_state_n = S_RISE;
                    w_load    = 1'b1;
                end
            end
            S_RISE: begin
                w_acc_n        = w_acc_rise;
                w_period_cnt_n = r_period_cnt + 16'd1;
                w_rise_cnt_n   = r_rise_cnt + RCNT_W'(1);
                if (r_rise_cnt == c_rise_last) begin
                    w_state_n    = S_DECAY;
                    w_rise_cnt_n = '0;
                    w_peak_n     = 1'b1;
                end
            end
            S_DECAY: begin
                w_acc_n        = w_acc_decay;
                w_period_cnt_n = r_period_cnt + 16'd1;
                if (r_period == 16'd0) begin
                    if (w_acc_int == '0) begin
                        w_state_n = S_IDLE;
                        w_acc_n   = '0;
                    end
                end else if (w_period_hit) begin
                    // Retrigger on top of the live tail: acc is kept.
                    w_state_n      = S_RISE;
                    w_period_cnt_n = '0;
                    w_rise_cnt_n   = '0;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_acc_n   = '0;
            end
        endcase
        if (stop && (r_state != S_IDLE)) begin
            w_state_n      = S_IDLE;
            w_acc_n        = '0;
            w_rise_cnt_n   = '0;
            w_period_cnt_n = '0;
            w_peak_n       = 1'b0;
        end
    end

    // In IDLE the live baseline feeds the output so pedestal changes show at once.
    assign w_base_sel = (r_state == S_IDLE) ? baseline : r_base;
    assign w_sum      = {1'b0, w_base_sel} + {1'b0, w_acc_int};

`ifdef V4_PULSE_GEN_NOISE_EN
    logic [15:0]       r_lfsr;
    logic              w_lfsr_fb;
    logic [DATA_W+2:0] w_noisy;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_noisy   = {2'b00, w_sum} + {{DATA_W{r_lfsr[2]}}, r_lfsr[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    always_comb begin
        if (w_noisy[DATA_W+2]) begin
            w_out_n = '0;
        end else if (w_noisy[DATA_W+1:DATA_W] != 2'b00) begin
            w_out_n = c_data_max;
        end else begin
            w_out_n = w_noisy[DATA_W-1:0];
        end
    end
`else
    assign w_out_n = w_sum[DATA_W] ? c_data_max : w_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_rise_cnt   <= '0;
            r_period_cnt <= '0;
            r_amp        <= '0;
            r_base       <= '0;
            r_period     <= '0;
            r_peak       <= 1'b0;
            r_busy       <= 1'b0;
            r_strobe     <= 1'b0;
            r_out        <= '0;
        end else begin
            r_state      <= w_state_n;
            r_acc        <= w_acc_n;
            r_rise_cnt   <= w_rise_cnt_n;
            r_period_cnt <= w_period_cnt_n;
            r_peak       <= w_peak_n;
            r_strobe     <= r_peak;
            r_busy       <= (r_state != S_IDLE) && (w_state_n != S_IDLE);
            r_out        <= w_out_n;
            if (r_state == S_IDLE) begin
                r_base <= baseline;
            end
            if (w_load) begin
                r_amp    <= amplitude;
                r_period <= period;
            end
        end
    end

    assign busy         = r_busy;
    assign pulse_strobe = r_strobe;
    assign output_data  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_v4_pulse_generator.sv
`default_nettype none
// Scoreboard bench for v4_pulse_generator: random pulse scenarios against a
// phase-indexed pulse-shape model, plus directed spot values.
module tb_v4_pulse_generator;

    localparam int     FRAC_W      = 12;
    localparam int     RISE_LEN    = 4;
    localparam int     DECAY_SHIFT = 5;
    localparam int     DMAX        = 4095;
    localparam longint ACC_MAX     = 64'd16777215;
    localparam int     MAXL        = 400;
`ifdef V4_PULSE_GEN_NOISE_EN
    localparam int     NOISE_LO    = 4;
    localparam int     NOISE_HI    = 3;
`else
    localparam int     NOISE_LO    = 0;
    localparam int     NOISE_HI    = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [11:0] amplitude, baseline;
    logic [15:0] period;
    logic        busy, pulse_strobe;
    logic [11:0] output_data;

    v4_pulse_generator dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .amplitude    (amplitude),
        .baseline     (baseline),
        .period       (period),
        .busy         (busy),
        .pulse_strobe (pulse_strobe),
        .output_data  (output_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int out; bit strobe; bit busy; bit tol; } exp_t;
    typedef struct { int cyc; int kind; int val; string name; } dir_t;
    exp_t sb[$];
    dir_t dq[$];

    bit st_start[MAXL], st_stop[MAXL], st_rst[MAXL];
    int st_amp[MAXL], st_base[MAXL], st_per[MAXL];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int expv, input bit tol);
        int lo, hi;
        lo = tol ? expv - NOISE_LO : expv;
        hi = tol ? expv + NOISE_HI : expv;
        if (lo < 0) lo = 0;
        if (hi > DMAX) hi = DMAX;
        if (lo > expv) lo = expv;
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
        end
    endtask

    // Pulse shape by phase: edges 1..RISE_LEN after a trigger add amp/RISE_LEN
    // of full scale, later edges shed 1/32 of the accumulator; output lags by one edge.
    task automatic model_push(input int L, input int e0);
        int t0, trig, base_l, per_l, peff, phase, outv;
        longint a, step;
        bit alive, stb;
        exp_t e;
        t0 = -1;
        for (int k = 0; k < L; k++)
            if (t0 < 0 && st_start[k] && !st_stop[k] && !st_rst[k]) t0 = k;
        alive = 0; a = 0; step = 0; trig = 0; base_l = 0; per_l = 0; peff = 0;
        for (int k = 0; k < L; k++) begin
            stb = 0;
            if (st_rst[k]) begin
                outv = 0; alive = 0; a = 0;
            end else if (!alive) begin
                outv = st_base[k];
                if (k == t0) begin
                    alive  = 1; trig = k; a = 0;
                    step   = longint'(st_amp[k]) * (longint'(1) << FRAC_W) / RISE_LEN;
                    base_l = st_base[k];
                    per_l  = st_per[k];
                    peff   = (per_l < RISE_LEN + 1) ? RISE_LEN + 1 : per_l;
                end
            end else begin
                outv  = base_l + int'(a >> FRAC_W);
                if (outv > DMAX) outv = DMAX;
                phase = k - trig;
                stb   = (phase == RISE_LEN + 1);
                if (st_stop[k]) begin
                    alive = 0; a = 0;
                end else if (phase >= 1 && phase <= RISE_LEN) begin
                    a = a + step;
                    if (a > ACC_MAX) a = ACC_MAX;
                end else if (per_l == 0 && (a >> FRAC_W) == 0) begin
                    alive = 0; a = 0;
                end else begin
                    if (per_l != 0 && phase == peff) trig = k;
                    a = a - (a >> DECAY_SHIFT);
                end
            end
            e.cyc = e0 + k; e.out = outv; e.strobe = stb;
            e.busy = alive && (k != t0); e.tol = !st_rst[k];
            sb.push_back(e);
        end
    endtask

    task automatic clear_stim(input int L, input int amp, input int base, input int per);
        for (int k = 0; k < L; k++) begin
            st_start[k] = 0; st_stop[k] = 0; st_rst[k] = 0;
            st_amp[k] = amp; st_base[k] = base; st_per[k] = per;
        end
    endtask

    task automatic begin_scn(input int L, output int e0);
        @(negedge clk);
        e0 = cyc + 1;
        model_push(L, e0);
    endtask

    task automatic drive_scn(input int L);
        for (int k = 0; k < L; k++) begin
            reset = st_rst[k]; start = st_start[k]; stop = st_stop[k];
            amplitude = 12'(st_amp[k]); baseline = 12'(st_base[k]); period = 16'(st_per[k]);
            @(negedge clk);
        end
        start = 0;
    endtask

    task automatic dir(input int c, input int kind, input int val, input string name);
        dir_t d;
        d.cyc = c; d.kind = kind; d.val = val; d.name = name;
        dq.push_back(d);
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        exp_t e;
        dir_t d;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("out", int'(output_data), e.out, e.tol);
                check("strobe", int'(pulse_strobe), int'(e.strobe), 1'b0);
                check("busy", int'(busy), int'(e.busy), 1'b0);
            end
            while (dq.size() > 0 && dq[0].cyc <= cyc) begin
                d = dq.pop_front();
                case (d.kind)
                    0: check(d.name, int'(output_data), d.val, 1'b1);
                    1: begin
                        total++;
                        if (!(int'(output_data) > d.val)) begin
                            bad++;
                            $display("FAIL %s cyc=%0d got=%0d want>%0d", d.name, cyc, output_data, d.val);
                        end
                    end
                    2: check(d.name, int'(pulse_strobe), d.val, 1'b0);
                    default: check(d.name, int'(busy), d.val, 1'b0);
                endcase
            end
        end
    end

    initial begin
        int e0, T, L, t0, sel, amp, base, per;
        reset = 1; start = 0; stop = 0; amplitude = 0; baseline = 0; period = 0;
        repeat (2) @(negedge clk);

        // Single shot amp=1024 base=100, reset state first, starts while busy ignored
        clear_stim(300, 1024, 100, 0);
        st_rst[0] = 1; st_rst[1] = 1; st_start[3] = 1; st_start[5] = 1; st_start[6] = 1;
        st_stop[298] = 1; st_stop[299] = 1;
        begin_scn(300, e0);
        T = e0 + 3;
        dir(e0, 0, 0, "reset_out"); dir(e0, 2, 0, "reset_strobe"); dir(e0, 3, 0, "reset_busy");
        dir(T, 0, 100, "idle_base"); dir(T, 3, 0, "busy_at_start_edge");
        dir(T + 1, 0, 100, "rise0"); dir(T + 1, 3, 1, "busy_rise");
        dir(T + 2, 0, 356, "rise1"); dir(T + 3, 0, 612, "rise2"); dir(T + 4, 0, 868, "rise3");
        dir(T + 4, 2, 0, "no_early_strobe");
        dir(T + 5, 0, 1124, "peak"); dir(T + 5, 2, 1, "peak_strobe");
        dir(T + 6, 0, 1092, "decay1"); dir(T + 6, 2, 0, "strobe_1cyc");
        dir(T + 7, 0, 1061, "decay2");
        drive_scn(300);

        // Saturation at output
        clear_stim(330, 4000, 200, 0);
        st_start[2] = 1; st_stop[328] = 1; st_stop[329] = 1;
        begin_scn(330, e0);
        T = e0 + 2;
        dir(T + 5, 0, 4095, "sat_peak"); dir(T + 5, 2, 1, "sat_strobe");
        dir(T + 6, 0, 4075, "sat_decay");
        drive_scn(330);

        // Reset held 3 cycles mid-decay
        clear_stim(40, 2000, 300, 0);
        st_start[2] = 1; st_rst[30] = 1; st_rst[31] = 1; st_rst[32] = 1;
        begin_scn(40, e0);
        for (int k = 30; k <= 32; k++) begin
            dir(e0 + k, 0, 0, "rst_mid_out"); dir(e0 + k, 3, 0, "rst_mid_busy");
        end
        dir(e0 + 33, 0, 300, "post_rst_idle"); dir(e0 + 33, 3, 0, "post_rst_busy");
        drive_scn(40);

        // Periodic, pile-up and stop mid-decay
        clear_stim(60, 512, 0, 20);
        st_start[2] = 1; st_stop[52] = 1; st_stop[58] = 1; st_stop[59] = 1;
        begin_scn(60, e0);
        T = e0 + 2;
        dir(T + 5, 0, 512, "per_peak1"); dir(T + 5, 2, 1, "per_strobe1");
        dir(T + 24, 2, 0, "per_nostrobe"); dir(T + 25, 2, 1, "per_strobe2");
        dir(T + 25, 1, 512, "pileup_peak"); dir(T + 45, 2, 1, "per_strobe3");
        dir(T + 49, 3, 1, "per_busy"); dir(T + 50, 3, 0, "stop_busy");
        dir(T + 51, 0, 0, "stop_out");
        drive_scn(60);

        // Accumulator saturation under fast retrigger (period below minimum)
        clear_stim(60, 4095, 0, 1);
        st_start[1] = 1; st_stop[58] = 1; st_stop[59] = 1;
        begin_scn(60, e0);
        T = e0 + 1;
        dir(T + 10, 2, 1, "min_period_strobe"); dir(T + 40, 0, 4095, "acc_sat_out");
        drive_scn(60);

        // Randomized scenarios
        for (int n = 0; n < 10; n++) begin
            amp  = $urandom_range(0, 4095);
            base = $urandom_range(0, 4095);
            sel  = $urandom_range(0, 2);
            per  = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 6) : $urandom_range(8, 40);
            L    = (per == 0) ? 330 : 120;
            clear_stim(L, amp, base, per);
            t0 = $urandom_range(1, 4);
            st_start[t0] = 1;
            if ($urandom_range(0, 1) == 1) begin
                st_start[t0 - 1] = 1; st_stop[t0 - 1] = 1;
            end
            for (int k = t0 + 1; k <= t0 + RISE_LEN + 1; k++) st_start[k] = 1'($urandom_range(0, 1));
            for (int k = t0 + 1; k < L; k++) begin
                st_base[k] = $urandom_range(0, 4095);
                st_amp[k]  = $urandom_range(0, 4095);
                st_per[k]  = $urandom_range(0, 40);
            end
            if (per != 0 || $urandom_range(0, 1) == 1) st_stop[$urandom_range(t0 + 7, L - 5)] = 1;
            st_stop[L - 2] = 1; st_stop[L - 1] = 1;
            begin_scn(L, e0);
            drive_scn(L);
        end

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() + dq.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size() + dq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
